lc3b_fetch: RTL
===============

Name: lc3b_fetch

Overview:
- Instruction-fetch initiator for the LC-3b pipeline.
- Holds the fetch PC and issues word reads to instruction memory.
- Delivers each returned instruction into the decode-stage instruction register using the load/resp/flush handshake.
- Handles downstream stalls with a one-entry hold buffer, and branch redirects by squashing in-flight or buffered fetches.

Parameters:
- RESET_PC, 16'h0000, fetch address after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- imem_read  out  1  read request to instruction memory
- imem_address  out  16  word address of outstanding read
- imem_rdata  in  16  returned instruction
- imem_resp  in  1  one-cycle pulse; imem_rdata valid this cycle
- stall  in  1  decode cannot accept a new instruction this cycle
- redirect  in  1  branch/jump taken; squash and refetch
- redirect_pc  in  16  new fetch target, valid with redirect
- ir_load  out  1  load ir_in into instruction register this cycle
- ir_in  out  16  instruction to load
- ir_resp  out  1  instruction register holds a valid instruction
- ir_flush  out  1  clear instruction register
- ir_pc  out  16  PC of the instruction currently in the IR

Behaviour:
- Internal registers:
  - state {FETCH, HOLD, KILL}
  - req_pc (16): address of current/next request
  - pending_pc (16)
  - held_instr (16)
  - ir_valid
  - ir_pc
- Reset (synchronous, highest priority):
  - state=FETCH, req_pc=RESET_PC, pending_pc=0, held_instr=0, ir_valid=0, ir_pc=0.
  - During the reset cycle, all combinational outputs are forced to 0: imem_read, ir_load, ir_flush.
  - Reset mid-request: any later imem_resp for the aborted read arrives in FETCH and is accepted as the response to RESET_PC. The memory is required to abort on reset.
- imem_read=1 in FETCH and KILL, 0 in HOLD.
- imem_address=req_pc always; it is stable from request until imem_resp.
- ir_flush=redirect (combinational, same cycle).
- ir_load is combinational and is never asserted in a redirect cycle.
- ir_in = imem_rdata in FETCH, held_instr in HOLD.
- ir_resp=ir_valid:
  - set on any ir_load;
  - cleared on redirect (flush);
  - otherwise held.
- ir_pc <= instruction's address on each ir_load.
- FETCH transitions:
  - redirect & imem_resp: discard data; req_pc<=redirect_pc; stay FETCH.
  - redirect & !imem_resp: pending_pc<=redirect_pc; go KILL. The outstanding read must complete and is discarded.
  - imem_resp & !stall: ir_load=1, ir_in=imem_rdata, ir_pc<=req_pc, req_pc<=req_pc+2; stay FETCH. The next read is issued the following cycle (1 issue per response, no bubble added).
  - imem_resp & stall: held_instr<=imem_rdata; go HOLD.
  - otherwise: wait, holding request.
- HOLD transitions:
  - redirect: drop held_instr; req_pc<=redirect_pc; go FETCH.
  - !stall: ir_load=1, ir_in=held_instr, ir_pc<=req_pc, req_pc<=req_pc+2; go FETCH.
  - stall: remain; ir_valid unchanged.
- KILL transitions:
  - redirect: pending_pc<=redirect_pc, with the latest target winning; remain.
  - imem_resp: discard; req_pc<=pending_pc; go FETCH. If redirect occurs the same cycle, req_pc<=redirect_pc instead.
  - No ir_load in KILL.
- Arithmetic: PC increment is 16-bit modulo. 16'hFFFE+2 wraps to 16'h0000.
- redirect_pc is used as given; bit 0 is not masked.

Test Plan:
- Reset with RESET_PC=16'h3000; memory returns 16'h1234, 16'h5678 with 2-cycle latency -> imem_address 3000, 3002, 3004; ir_load pulses with ir_in 1234 then 5678; ir_pc 3000 then 3002; ir_resp=1 after the first load.
- Stall asserted 3 cycles over the response to 16'h3002 -> state HOLD; imem_read=0; no ir_load until stall drops; then ir_in=held 16'h5678; the next request is to 3004.
- Redirect to 16'h4000 while the read of 3004 is outstanding -> ir_flush=1 same cycle; ir_resp=0 next; imem_address stays 3004 until resp; that data is not loaded; next request is to 4000.
- Redirect and imem_resp in the same FETCH cycle, redirect_pc=16'h5000 -> no ir_load; next imem_address=5000.
- Two redirects in KILL (6000 then 7000) -> after the discarded response, the fetch goes to 7000.
- req_pc=16'hFFFE, response 16'h0000, no stall -> ir_pc=FFFE; next imem_address=16'h0000.

Source files
------------

// File: rtl/lc3b_fetch.sv
// rtl/lc3b_fetch.sv - LC-3b instruction fetch initiator with hold buffer and redirect squash
module lc3b_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic [15:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ir_load,
  output logic [15:0] ir_in,
  output logic        ir_resp,
  output logic        ir_flush,
  output logic [15:0] ir_pc
);

  typedef enum logic [1:0] {FETCH, HOLD, KILL} state_t;

  state_t      state, state_next;
  logic [15:0] req_pc, req_pc_next;
  logic [15:0] pending_pc, pending_pc_next;
  logic [15:0] held_instr, held_instr_next;
  logic        ir_valid;
  logic [15:0] ir_pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      req_pc     <= RESET_PC;
      pending_pc <= 16'h0000;
      held_instr <= 16'h0000;
      ir_valid   <= 1'b0;
      ir_pc_q    <= 16'h0000;
    end else begin
      state      <= state_next;
      req_pc     <= req_pc_next;
      pending_pc <= pending_pc_next;
      held_instr <= held_instr_next;
      if (redirect)
        ir_valid <= 1'b0;
      else if (ir_load)
        ir_valid <= 1'b1;
      // req_pc still names the instruction being loaded in the load cycle
      if (ir_load)
        ir_pc_q <= req_pc;
    end
  end

  always_comb begin
    state_next      = state;
    req_pc_next     = req_pc;
    pending_pc_next = pending_pc;
    held_instr_next = held_instr;
    imem_read       = 1'b0;
    ir_load         = 1'b0;
    ir_flush        = 1'b0;
    if (!reset) begin
      ir_flush = redirect;
      case (state)
        FETCH: begin
          imem_read = 1'b1;
          if (redirect) begin
            if (imem_resp) begin
              req_pc_next = redirect_pc;
            end else begin
              // the outstanding read cannot be cancelled; park the target until it returns
              pending_pc_next = redirect_pc;
              state_next      = KILL;
            end
          end else if (imem_resp) begin
            if (!stall) begin
              ir_load     = 1'b1;
              req_pc_next = req_pc + 16'd2;
            end else begin
              held_instr_next = imem_rdata;
              state_next      = HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            req_pc_next = redirect_pc;
            state_next  = FETCH;
          end else if (!stall) begin
            ir_load     = 1'b1;
            req_pc_next = req_pc + 16'd2;
            state_next  = FETCH;
          end
        end
        KILL: begin
          imem_read = 1'b1;
          if (imem_resp) begin
            req_pc_next = redirect ? redirect_pc : pending_pc;
            state_next  = FETCH;
          end else if (redirect) begin
            pending_pc_next = redirect_pc;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  assign imem_address = req_pc;
  assign ir_in        = (state == HOLD) ? held_instr : imem_rdata;
  assign ir_resp      = ir_valid;
  assign ir_pc        = ir_pc_q;

endmodule
